uart_receiver: RTL
==================

# uart_receiver

Serial-to-parallel UART receive stage sitting directly downstream of the baud rate generator. Consumes the 16x-oversampling tick, synchronises the asynchronous `rx` line, and locates each start-bit midpoint. Samples data, optional parity and stop bits at bit centres. Delivers the received byte through a valid/ack holding register, with framing, parity and overrun error pulses.

## Interface
Parameters:
- `DATA_BITS`, 8, data bits per frame, legal 5..8
- `PARITY_EN`, 0, 1 = parity bit follows the data bits
- `PARITY_ODD`, 0, 1 = odd parity, 0 = even (ignored when `PARITY_EN`=0)

Ports:
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  reset; asynchronous, active-high
- `rx_tick`  in  1  one-`clk` pulse at 16x baud rate
- `rx`  in  1  asynchronous serial input, idle high
- `rx_data`  out  8  received data, LSB-aligned; unused upper bits 0
- `rx_valid`  out  1  `rx_data` holds an unread frame
- `rx_ack`  in  1  consumer read; clears `rx_valid`
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0
- `parity_err`  out  1  one-cycle pulse: parity mismatch
- `overrun_err`  out  1  one-cycle pulse: good frame dropped, holding register full

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1) to give `rx_s`. All decisions use `rx_s`.
- A 4-bit tick counter `tcnt` advances only on `rx_tick`. `bidx` counts data bits.
- **IDLE**: on `rx_tick` with `rx_s`=0 → START, `tcnt`=0.
- **START**: on `rx_tick`, `tcnt`++. At `tcnt`==7 (mid-bit), sample `rx_s`:
  - 0 → DATA, `tcnt`=0, `bidx`=0
  - 1 → false start, back to IDLE
- **DATA**: at `tcnt`==15 with `rx_tick`, shift `rx_s` in LSB-first and increment `bidx`. After `DATA_BITS` samples → PARITY if `PARITY_EN`, else STOP.
- **PARITY**: at `tcnt`==15, sample. Mismatch = XOR(data, sampled bit) ≠ `PARITY_ODD`.
- **STOP**: at `tcnt`==15, sample the stop bit, then complete the frame:
  - stop=0: `frame_err` pulse → BREAK
  - stop=1, parity bad: `parity_err` pulse → IDLE
  - stop=1, good: deliver the frame → IDLE
- **BREAK**: wait until `rx_s`==1, then → IDLE. A line held low never re-triggers a start.
- Errored frames are never loaded into `rx_data`.
- Delivery of a good frame:
  - `rx_valid`=0, or `rx_ack`=1 in the same cycle: load `rx_data`, set `rx_valid`=1.
  - otherwise: pulse `overrun_err`, discard the new frame, keep the old data.
- `rx_ack` with `rx_valid`=1 and no delivery that cycle → `rx_valid`=0. `rx_ack` while `rx_valid`=0 is ignored.

## Timing
- Reset values: state IDLE; all outputs 0, including `rx_data`; synchroniser flops 1.
- `rst` mid-frame aborts immediately. No error pulse is generated.
- Input-to-FSM latency is 2 `clk` through the synchroniser.
- `rx_valid`, `rx_data` and the error pulses register on the `clk` edge after the `rx_tick` that samples the stop bit.
- Error pulses last exactly 1 `clk`. At most one error pulse per frame.
- Start midpoint is 8 ticks after detection. Later bits are 16 ticks apart.
- `tcnt` wraps 15→0 with no extra tick.
- `rx_tick` may be high on consecutive cycles (tied high in test). Behaviour is identical in tick units.

## Structure
- Package `uart_pkg`: `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP, BREAK), `OVERSAMPLE`=16, `MID_TICK`=7, `LAST_TICK`=15.
- Sub-module `uart_sync2`: 2-flop synchroniser with reset value parameter. Instantiated once for `rx`.

## Test plan
All scenarios tie `rx_tick`=1, giving 16 `clk` per bit.
- **Good frame, ack**: frame 0xA5, 8N1, then `rx_ack` one cycle after `rx_valid` → `rx_data`=0xA5, `rx_valid` high until the ack, no errors.
- **False start**: `rx` low for 4 ticks, then high → FSM returns to IDLE, no `rx_valid`, no error.
- **Parity**: `PARITY_EN`=1, `PARITY_ODD`=0, 0x3C sent with parity bit 1 → `parity_err` 1-cycle pulse, `rx_valid` stays 0. Resend with parity bit 0 → `rx_data`=0x3C.
- **Framing/break**: 0x55 with stop=0, `rx` held low 100 ticks, then frame 0x0F → `frame_err` pulse once, no spurious starts during the low period, then `rx_data`=0x0F.
- **Overrun**: 0x11 left unacked, then 0x22 → `overrun_err` pulse, `rx_data` stays 0x11. Repeat with `rx_ack` coincident with 0x22 completion → `rx_data`=0x22, no error.
- **Reset mid-frame**: assert `rst` during bit 3 of 0xFF → all outputs 0. A following frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned TCNT_W     = $clog2(OVERSAMPLE);
    localparam int unsigned MID_TICK   = 7;
    localparam int unsigned LAST_TICK  = 15;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned BIDX_W     = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    // Mismatch when the ones-count of data plus parity bit disagrees with the selected sense.
    function automatic logic parity_mismatch(
        input logic [DATA_W-1:0] data,
        input logic              par_bit,
        input logic              odd
    );
        return ((^data) ^ par_bit) != odd;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 16x-oversampled start detection, bit-centre sampling and
// a valid/ack holding register with framing, parity and overrun error pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_tick,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun_err
);

    rx_state_t r_state;
    rx_state_t w_next_state;

    logic              w_rx_s;
    logic [TCNT_W-1:0] r_tcnt;
    logic [BIDX_W-1:0] r_bidx;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_bad;

    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_frame_err;
    logic              r_parity_err;
    logic              r_overrun_err;

    logic w_mid;
    logic w_last;
    logic w_last_bit;

    logic w_start_det;
    logic w_data_go;
    logic w_tcnt_inc;
    logic w_bit_en;
    logic w_par_en;
    logic w_frame_bad;
    logic w_par_fail;
    logic w_deliver;

    uart_sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync_rx (
        .clk(clk),
        .rst(rst),
        .i_d(rx),
        .o_q(w_rx_s)
    );

    assign w_mid      = (r_tcnt == TCNT_W'(MID_TICK));
    assign w_last     = (r_tcnt == TCNT_W'(LAST_TICK));
    assign w_last_bit = (r_bidx == BIDX_W'(DATA_BITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (rx_tick && !w_rx_s) w_next_state = START;
            end
            START: begin
                if (rx_tick && w_mid) w_next_state = w_rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (rx_tick && w_last && w_last_bit) begin
                    w_next_state = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (rx_tick && w_last) w_next_state = STOP;
            end
            STOP: begin
                if (rx_tick && w_last) w_next_state = w_rx_s ? IDLE : BREAK;
            end
            BREAK: begin
                // A held-low line must see a high level before another start can arm.
                if (w_rx_s) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_start_det = 1'b0;
        w_data_go   = 1'b0;
        w_tcnt_inc  = 1'b0;
        w_bit_en    = 1'b0;
        w_par_en    = 1'b0;
        w_frame_bad = 1'b0;
        w_par_fail  = 1'b0;
        w_deliver   = 1'b0;
        case (r_state)
            IDLE: begin
                w_start_det = rx_tick && !w_rx_s;
            end
            START: begin
                w_data_go  = rx_tick && w_mid && !w_rx_s;
                w_tcnt_inc = rx_tick && !w_data_go;
            end
            DATA: begin
                w_tcnt_inc = rx_tick;
                w_bit_en   = rx_tick && w_last;
            end
            PARITY: begin
                w_tcnt_inc = rx_tick;
                w_par_en   = rx_tick && w_last;
            end
            STOP: begin
                w_tcnt_inc = rx_tick;
                if (rx_tick && w_last) begin
                    w_frame_bad = !w_rx_s;
                    w_par_fail  = w_rx_s && r_par_bad;
                    w_deliver   = w_rx_s && !r_par_bad;
                end
            end
            default: begin
            end
        endcase
    end

    // Bit timing and frame assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt    <= '0;
            r_bidx    <= '0;
            r_shift   <= '0;
            r_par_bad <= 1'b0;
        end else begin
            if (w_start_det || w_data_go) begin
                r_tcnt <= '0;
            end else if (w_tcnt_inc) begin
                r_tcnt <= r_tcnt + TCNT_W'(1);
            end

            if (w_data_go) begin
                r_bidx <= '0;
            end else if (w_bit_en) begin
                r_bidx <= r_bidx + BIDX_W'(1);
            end

            if (w_start_det) begin
                r_shift <= '0;
            end else if (w_bit_en) begin
                r_shift[r_bidx] <= w_rx_s;
            end

            if (w_start_det) begin
                r_par_bad <= 1'b0;
            end else if (w_par_en) begin
                r_par_bad <= parity_mismatch(r_shift, w_rx_s, PARITY_ODD != 0);
            end
        end
    end

    // Holding register and error pulses; an ack in the delivery cycle frees the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_parity_err  <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_frame_err   <= w_frame_bad;
            r_parity_err  <= w_par_fail;
            r_overrun_err <= w_deliver && r_rx_valid && !rx_ack;
            if (w_deliver && (!r_rx_valid || rx_ack)) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (rx_ack) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_err   = r_frame_err;
    assign parity_err  = r_parity_err;
    assign overrun_err = r_overrun_err;

endmodule
